// File: rtl/spi_reg_loader.sv
// SPI mode-0 slave that turns 16-bit frames into single-cycle register writes in the clk domain.
// Strobe latency is SYNC_STAGES+1 clk after cs_n rise is sampled; no backpressure, one write per frame.
module spi_reg_loader #(
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              frame_err
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic [SYNC_STAGES:0]   vld_q;
    logic                   armed_q, armed_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, cs_rise, cs_fall;
    logic sclk_rise_q, cs_rise_q, cs_fall_q, mosi_q;

    logic [15:0]       shift_q, shift_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              strobe_q, strobe_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // A falling cs_n only opens a frame once a genuine idle-high level has been
    // seen since reset, so a frame cut by reset is ignored until cs_n cycles.
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q & armed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            vld_q       <= '0;
            armed_q     <= 1'b0;
            sclk_rise_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            vld_q       <= {vld_q[SYNC_STAGES-1:0], 1'b1};
            armed_q     <= armed_d;
            sclk_rise_q <= sclk_rise;
            cs_rise_q   <= cs_rise;
            cs_fall_q   <= cs_fall;
            mosi_q      <= mosi_s;
        end
    end

    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        err_d    = err_q;
        strobe_d = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        armed_d  = armed_q | (vld_q[SYNC_STAGES] & cs_prev_q);
        if (cs_fall_q) begin
            shift_d = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
        end else if (cs_rise_q) begin
            // a coincident sclk rise is dropped; classify on bits already counted
            busy_d = 1'b0;
            if (busy_q) begin
                if (cnt_q == 5'd16) begin
                    if (shift_q[15]) begin
                        strobe_d = 1'b1;
                        addr_d   = shift_q[8 +: ADDR_W];
                        data_d   = shift_q[DATA_W-1:0];
                        err_d    = 1'b0;
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (sclk_rise_q && busy_q) begin
            shift_d = {shift_q[14:0], mosi_q};
            if (cnt_q != 5'd17) begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            strobe_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            strobe_q <= strobe_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign wr_strobe = strobe_q;
    assign wr_addr   = addr_q;
    assign wr_data   = data_q;
    assign busy      = busy_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_spi_reg_loader.sv
// Bench for spi_reg_loader: frame table plus hand-written latency, reset and idle-sclk sequences.
module tb_spi_reg_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       wr_strobe;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       frame_err;

    spi_reg_loader #(.ADDR_W(3), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] bits;
        int          n;
        bit          strobe;
        logic [2:0]  addr;
        logic [7:0]  data;
        bit          err;
    } vec_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  nstrobe = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest pending expected write.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wr_strobe === 1'b1) begin
                nstrobe++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("sb_addr", {29'd0, wr_addr}, {29'd0, e.addr});
                    chk("sb_data", {24'd0, wr_data}, {24'd0, e.data});
                end
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves cs_n low after the last bit.
    task automatic send_bits(input logic [31:0] bits, input int n);
        spi_cs_n = 1'b0;
        clks(6);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = bits[i];
            clks(5);
            spi_sclk = 1'b1;
            clks(5);
            spi_sclk = 1'b0;
        end
        clks(5);
    endtask

    task automatic frame(input logic [31:0] bits, input int n, input int gap);
        send_bits(bits, n);
        spi_cs_n = 1'b1;
        clks(gap);
    endtask

    task automatic expect_wr(input logic [2:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    vec_t vecs[6];

    initial begin
        int base;

        vecs[0] = '{32'h0333,  16, 1'b0, 3'd2, 8'h5C, 1'b0};
        vecs[1] = '{32'h1234,  15, 1'b0, 3'd2, 8'h5C, 1'b1};
        vecs[2] = '{32'h3FFFF, 18, 1'b0, 3'd2, 8'h5C, 1'b1};
        vecs[3] = '{32'h81FF,  16, 1'b1, 3'd1, 8'hFF, 1'b0};
        vecs[4] = '{32'h0000,   0, 1'b0, 3'd1, 8'hFF, 1'b1};
        vecs[5] = '{32'h8733,  16, 1'b1, 3'd7, 8'h33, 1'b0};

        clks(3);
        chk("rst_strobe", {31'd0, wr_strobe}, 32'd0);
        chk("rst_addr",   {29'd0, wr_addr},   32'd0);
        chk("rst_data",   {24'd0, wr_data},   32'd0);
        chk("rst_busy",   {31'd0, busy},      32'd0);
        chk("rst_err",    {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        clks(6);

        // First frame: exact strobe latency and busy tracking.
        expect_wr(3'd2, 8'h5C);
        send_bits(32'h8A5C, 16);
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
        spi_cs_n = 1'b1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("lat_strobe_early", {31'd0, wr_strobe}, 32'd0);
        chk("lat_busy_early",   {31'd0, busy},      32'd1);
        @(posedge clk);
        #1;
        chk("lat_strobe_on", {31'd0, wr_strobe}, 32'd1);
        chk("lat_busy_off",  {31'd0, busy},      32'd0);
        chk("lat_addr",      {29'd0, wr_addr},   32'd2);
        chk("lat_data",      {24'd0, wr_data},   32'h5C);
        @(posedge clk);
        #1;
        chk("lat_strobe_off", {31'd0, wr_strobe}, 32'd0);
        chk("lat_err", {31'd0, frame_err}, 32'd0);
        clks(4);

        for (int i = 0; i < 6; i++) begin
            base = nstrobe;
            if (vecs[i].strobe) expect_wr(vecs[i].addr, vecs[i].data);
            frame(vecs[i].bits, vecs[i].n, 10);
            chk($sformatf("vec%0d_nstrobe", i), nstrobe - base, vecs[i].strobe ? 1 : 0);
            chk($sformatf("vec%0d_addr", i), {29'd0, wr_addr}, {29'd0, vecs[i].addr});
            chk($sformatf("vec%0d_data", i), {24'd0, wr_data}, {24'd0, vecs[i].data});
            chk($sformatf("vec%0d_err", i), {31'd0, frame_err}, {31'd0, vecs[i].err});
        end

        // Back-to-back at the minimum cs_n high gap.
        base = nstrobe;
        expect_wr(3'd0, 8'h11);
        expect_wr(3'd1, 8'h22);
        expect_wr(3'd7, 8'h33);
        frame(32'h8011, 16, 4);
        frame(32'h8122, 16, 4);
        frame(32'h8733, 16, 10);
        chk("b2b_nstrobe", nstrobe - base, 32'd3);
        chk("b2b_addr", {29'd0, wr_addr}, 32'd7);
        chk("b2b_data", {24'd0, wr_data}, 32'h33);

        // Reset in the middle of a frame with cs_n held low.
        frame(32'h5, 3, 10);
        chk("pre_rst_err", {31'd0, frame_err}, 32'd1);
        base = nstrobe;
        send_bits(32'h1FF, 9);
        rst_n = 1'b0;
        clks(3);
        chk("midrst_addr", {29'd0, wr_addr}, 32'd0);
        chk("midrst_err",  {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        send_bits(32'h7F, 7);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        spi_cs_n = 1'b1;
        clks(10);
        chk("midrst_nstrobe", nstrobe - base, 32'd0);
        chk("midrst_err_after", {31'd0, frame_err}, 32'd0);
        expect_wr(3'd4, 8'h44);
        frame(32'h8444, 16, 10);
        chk("post_rst_nstrobe", nstrobe - base, 32'd1);
        chk("post_rst_data", {24'd0, wr_data}, 32'h44);

        // sclk activity with cs_n high must be ignored.
        base = nstrobe;
        for (int i = 0; i < 20; i++) begin
            spi_mosi = i[0];
            spi_sclk = 1'b1;
            clks(5);
            spi_sclk = 1'b0;
            clks(5);
            if (i == 10) chk("idle_busy_mid", {31'd0, busy}, 32'd0);
        end
        clks(8);
        chk("idle_nstrobe", nstrobe - base, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_err", {31'd0, frame_err}, 32'd0);
        expect_wr(3'd2, 8'h55);
        frame(32'h8255, 16, 10);
        chk("idle_then_frame", nstrobe - base, 32'd1);
        chk("final_addr", {29'd0, wr_addr}, 32'd2);

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
